// File: rtl/action_regs_pkg.sv
// Shared constants for the action AXI-Lite register bank.
// Holds the byte offsets of the register map, the AXI response encodings
// and the state encodings of the write and read channel FSMs.
package action_regs_pkg;

    localparam int OFF_CTRL      = 'h00;
    localparam int OFF_GIE       = 'h04;
    localparam int OFF_IER       = 'h08;
    localparam int OFF_ISR       = 'h0C;
    localparam int OFF_USER_BASE = 'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/axilite_slave_if.sv
// AXI-Lite slave channel handling for the action register bank.
// Write side: collects AW and W in any order, issues a single-cycle wr_en
// strobe with address/data/strobes, then holds B until bready.
// Read side: accepts AR, issues a single-cycle rd_en strobe, registers the
// returned data/error and holds R until rready.
// Ports: s_axi_* slave bus (prot not needed here); wr_* / rd_* register-body
// interface, where wr_err / rd_err / rd_data come back combinationally.
module axilite_slave_if
    import action_regs_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic [1:0]            s_axi_bresp,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic [3:0]            wr_strb,
    input  logic                  wr_err,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [31:0]           rd_data,
    input  logic                  rd_err
);

    // Readies stay low while in reset and are only raised from the first
    // clock after release.
    logic r_live;

    wr_state_t r_wst, w_wst_nxt;
    rd_state_t r_rst, w_rst_nxt;

    logic                  r_aw_got, r_w_got;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;
    logic [1:0]            r_bresp;
    logic [31:0]           r_rdata;
    logic [1:0]            r_rresp;
    logic                  w_aw_hs, w_w_hs;

    assign s_axi_awready = r_live && (r_wst == W_IDLE) && !r_aw_got;
    assign s_axi_wready  = r_live && (r_wst == W_IDLE) && !r_w_got;
    assign s_axi_bvalid  = (r_wst == W_RESP);
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_live && (r_rst == R_IDLE);
    assign s_axi_rvalid  = (r_rst == R_DATA);
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;

    assign w_aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_w_hs  = s_axi_wvalid && s_axi_wready;

    // Use the live bus value when the beat arrives in the completing cycle.
    assign wr_addr = r_aw_got ? r_awaddr : s_axi_awaddr;
    assign wr_data = r_w_got  ? r_wdata  : s_axi_wdata;
    assign wr_strb = r_w_got  ? r_wstrb  : s_axi_wstrb;

    assign rd_en   = s_axi_arvalid && s_axi_arready;
    assign rd_addr = s_axi_araddr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_live <= 1'b0;
            r_wst  <= W_IDLE;
            r_rst  <= R_IDLE;
        end else begin
            r_live <= 1'b1;
            r_wst  <= w_wst_nxt;
            r_rst  <= w_rst_nxt;
        end
    end

    always_comb begin
        w_wst_nxt = r_wst;
        wr_en     = 1'b0;
        case (r_wst)
            W_IDLE: if ((r_aw_got || w_aw_hs) && (r_w_got || w_w_hs)) begin
                wr_en     = 1'b1;
                w_wst_nxt = W_RESP;
            end
            W_RESP: if (s_axi_bready) w_wst_nxt = W_IDLE;
            default: w_wst_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rst_nxt = r_rst;
        case (r_rst)
            R_IDLE:  if (rd_en) w_rst_nxt = R_DATA;
            R_DATA:  if (s_axi_rready) w_rst_nxt = R_IDLE;
            default: w_rst_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bresp  <= RESP_OKAY;
        end else if (wr_en) begin
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_aw_got <= 1'b1;
                r_awaddr <= s_axi_awaddr;
            end
            if (w_w_hs) begin
                r_w_got <= 1'b1;
                r_wdata <= s_axi_wdata;
                r_wstrb <= s_axi_wstrb;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (rd_en) begin
            r_rdata <= rd_err ? 32'd0 : rd_data;
            r_rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

endmodule

// File: rtl/action_axilite_regs.sv
// Action-side AXI-Lite register bank: CTRL (start/done/idle), GIE, IER,
// ISR and NUM_USER_REGS user RW registers starting at 0x10.
// Ports: clk/resetn, s_axi_* AXI-Lite slave, ap_start/ap_done_in/ap_idle_in
// action handshake, user_regs flat export, irq level interrupt.
module action_axilite_regs
    import action_regs_pkg::*;
#(
    parameter int NUM_USER_REGS = 8,
    parameter int ADDR_WIDTH    = 32
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [ADDR_WIDTH-1:0]       s_axi_awaddr,
    input  logic [2:0]                  s_axi_awprot,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    input  logic [31:0]                 s_axi_wdata,
    input  logic [3:0]                  s_axi_wstrb,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    output logic [1:0]                  s_axi_bresp,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    input  logic [ADDR_WIDTH-1:0]       s_axi_araddr,
    input  logic [2:0]                  s_axi_arprot,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic [31:0]                 s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        ap_start,
    input  logic                        ap_done_in,
    input  logic                        ap_idle_in,
    output logic [32*NUM_USER_REGS-1:0] user_regs,
    output logic                        irq
);

    localparam int WW = ADDR_WIDTH - 2;
    localparam logic [WW-1:0] W_CTRL  = WW'(OFF_CTRL >> 2);
    localparam logic [WW-1:0] W_GIE   = WW'(OFF_GIE >> 2);
    localparam logic [WW-1:0] W_IER   = WW'(OFF_IER >> 2);
    localparam logic [WW-1:0] W_ISR   = WW'(OFF_ISR >> 2);
    localparam logic [WW-1:0] W_USER0 = WW'(OFF_USER_BASE >> 2);
    localparam logic [WW-1:0] W_END   = WW'((OFF_USER_BASE >> 2) + NUM_USER_REGS);

    logic                  w_wr_en, w_rd_en, w_wr_err, w_rd_err;
    logic [ADDR_WIDTH-1:0] w_wr_addr, w_rd_addr;
    logic [31:0]           w_wr_data, w_rd_data;
    logic [3:0]            w_wr_strb;
    logic [WW-1:0]         w_wword, w_rword;
    logic                  w_unused;

    logic        r_start, r_done, r_gie, r_ier, r_isr;
    logic [31:0] r_user [NUM_USER_REGS];

    axilite_slave_if #(.ADDR_WIDTH(ADDR_WIDTH)) u_if (
        .clk(clk), .resetn(resetn),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data), .wr_strb(w_wr_strb),
        .wr_err(w_wr_err),
        .rd_en(w_rd_en), .rd_addr(w_rd_addr), .rd_data(w_rd_data), .rd_err(w_rd_err)
    );

    // Byte-offset bits [1:0] and the prot fields carry no meaning here.
    assign w_unused = ^{s_axi_awprot, s_axi_arprot, w_wr_addr[1:0], w_rd_addr[1:0]};

    assign w_wword  = w_wr_addr[ADDR_WIDTH-1:2];
    assign w_rword  = w_rd_addr[ADDR_WIDTH-1:2];
    assign w_wr_err = (w_wword >= W_END);
    assign w_rd_err = (w_rword >= W_END);

    assign ap_start = r_start;
    assign irq      = r_gie & r_ier & r_isr;

    // Set conditions are checked first so they win over clears.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_start <= 1'b0;
            r_done  <= 1'b0;
            r_gie   <= 1'b0;
            r_ier   <= 1'b0;
            r_isr   <= 1'b0;
        end else begin
            if (w_wr_en && w_wword == W_CTRL && w_wr_strb[0] && w_wr_data[0])
                r_start <= 1'b1;
            else if (ap_done_in)
                r_start <= 1'b0;

            if (ap_done_in)
                r_done <= 1'b1;
            else if (w_rd_en && w_rword == W_CTRL)
                r_done <= 1'b0;

            if (w_wr_en && w_wword == W_GIE && w_wr_strb[0]) r_gie <= w_wr_data[0];
            if (w_wr_en && w_wword == W_IER && w_wr_strb[0]) r_ier <= w_wr_data[0];

            if (ap_done_in)
                r_isr <= 1'b1;
            else if (w_wr_en && w_wword == W_ISR && w_wr_strb[0] && w_wr_data[0])
                r_isr <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NUM_USER_REGS; k++) r_user[k] <= '0;
        end else if (w_wr_en) begin
            for (int k = 0; k < NUM_USER_REGS; k++)
                if (w_wword == W_USER0 + WW'(k))
                    for (int b = 0; b < 4; b++)
                        if (w_wr_strb[b]) r_user[k][8*b +: 8] <= w_wr_data[8*b +: 8];
        end
    end

    always_comb begin
        w_rd_data = '0;
        if (w_rword == W_CTRL)     w_rd_data = {29'd0, ap_idle_in, r_done, r_start};
        else if (w_rword == W_GIE) w_rd_data = {31'd0, r_gie};
        else if (w_rword == W_IER) w_rd_data = {31'd0, r_ier};
        else if (w_rword == W_ISR) w_rd_data = {31'd0, r_isr};
        else
            for (int k = 0; k < NUM_USER_REGS; k++)
                if (w_rword == W_USER0 + WW'(k)) w_rd_data = r_user[k];
    end

    for (genvar k = 0; k < NUM_USER_REGS; k++) begin : g_user
        assign user_regs[32*k +: 32] = r_user[k];
    end

endmodule
